// File: rtl/uart_time_tx.sv
// Purpose: sends "MM:SS\r" for the selected channel over a UART line (8N1, or 8E1 with UART_TIME_TX_PARITY_EN).
// Latency: txd start bit begins one clock after the accepting edge; a frame occupies 60*CLK_DIV (66*CLK_DIV with parity) clocks.
// Backpressure: send is taken only while busy=0; requests during a frame are dropped, never queued.
module uart_time_tx #(
    parameter int CLK_DIV = 1085,
    parameter int SELW    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SELW-1:0]         ch_sel,
    input  logic [6*(2**SELW)-1:0]  mm_bus,
    input  logic [6*(2**SELW)-1:0]  ss_bus,
    input  logic                    send,
    output logic                    busy,
    output logic                    done,
    output logic                    txd
);

    // Baud counter is 12 bits wide, enough for the largest legal divider (4095).
    localparam logic [11:0] BAUD_LAST = 12'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TIME_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [11:0] baud_q,  baud_d;
    logic [2:0]  bit_q,   bit_d;
    logic [2:0]  chr_q,   chr_d;
    logic [5:0]  mm_q,    mm_d;
    logic [5:0]  ss_q,    ss_d;
    logic        done_q,  done_d;
    logic        txd_q,   txd_d;

    logic [5:0]  mm_sel, ss_sel;
    logic [5:0]  mm_sat, ss_sat;
    logic [5:0]  mm_tens, mm_ones, ss_tens, ss_ones;
    logic [7:0]  chr_byte;
    logic        bit_end;

    // Pick the requested channel's fields and format the latched time into the current character.
    always_comb begin
        mm_sel  = mm_bus[6*int'(ch_sel) +: 6];
        ss_sel  = ss_bus[6*int'(ch_sel) +: 6];
        // Out-of-range values are clamped so the digits never exceed "59".
        mm_sat  = (mm_q > 6'd59) ? 6'd59 : mm_q;
        ss_sat  = (ss_q > 6'd59) ? 6'd59 : ss_q;
        mm_tens = mm_sat / 6'd10;
        mm_ones = mm_sat % 6'd10;
        ss_tens = ss_sat / 6'd10;
        ss_ones = ss_sat % 6'd10;
        case (chr_q)
            3'd0:    chr_byte = 8'h30 + {2'b00, mm_tens};
            3'd1:    chr_byte = 8'h30 + {2'b00, mm_ones};
            3'd2:    chr_byte = 8'h3A;
            3'd3:    chr_byte = 8'h30 + {2'b00, ss_tens};
            3'd4:    chr_byte = 8'h30 + {2'b00, ss_ones};
            default: chr_byte = 8'h0D;
        endcase
        bit_end = (baud_q == BAUD_LAST);
    end

    // Frame sequencer: next state, baud/bit/char counters, input latches and done pulse.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        chr_d   = chr_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (send) begin
                state_d = S_START;
                baud_d  = 12'd0;
                bit_d   = 3'd0;
                chr_d   = 3'd0;
                mm_d    = mm_sel;
                ss_d    = ss_sel;
            end
        end else begin
            baud_d = bit_end ? 12'd0 : baud_q + 12'd1;
            case (state_q)
                S_START: begin
                    if (bit_end) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TIME_TX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TIME_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (chr_q == 3'd5) begin
                            state_d = S_IDLE;
                            chr_d   = 3'd0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_START;
                            chr_d   = chr_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    baud_d  = 12'd0;
                end
            endcase
        end
    end

    // Line level for the bit currently being timed; registered below so txd trails the state by one clock.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = chr_byte[bit_q];
`ifdef UART_TIME_TX_PARITY_EN
            S_PARITY: txd_d = ^chr_byte;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers; reset forces an idle-high line at once and discards any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= 12'd0;
            bit_q   <= 3'd0;
            chr_q   <= 3'd0;
            mm_q    <= 6'd0;
            ss_q    <= 6'd0;
            done_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            chr_q   <= chr_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            done_q  <= done_d;
            txd_q   <= txd_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign txd  = txd_q;

endmodule

// File: tb/tb_uart_time_tx.sv
// Purpose: directed checks of uart_time_tx with a UART receiver monitor scoring bytes against an expected queue.
// Latency: frames are 240 clocks (264 with UART_TIME_TX_PARITY_EN) at CLK_DIV=4.
// Backpressure: stimulus only pulses send; drops and back-to-back acceptance are checked via busy/done.
`timescale 1ns/1ps
module tb_uart_time_tx;

    localparam int CLK_DIV = 4;
    localparam int SELW    = 1;
`ifdef UART_TIME_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_CLKS = (PAR == 1) ? 264 : 240;
    localparam int STOP_K     = 9 + PAR;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst    = 1'b0;
    logic        send   = 1'b0;
    logic [0:0]  ch_sel = 1'b0;
    logic [11:0] mm_bus = '0;
    logic [11:0] ss_bus = '0;
    logic        busy, done, txd;

    uart_time_tx #(.CLK_DIV(CLK_DIV), .SELW(SELW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ch_sel (ch_sel),
        .mm_bus (mm_bus),
        .ss_bus (ss_bus),
        .send   (send),
        .busy   (busy),
        .done   (done),
        .txd    (txd)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    typedef struct {
        logic [7:0] b;
        logic       chkp;
        logic       p;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bytes[47:40] is the first character; par[5] is its parity bit.
    task automatic push6(input logic [47:0] bytes, input logic [5:0] par, input logic cp);
        exp_t e;
        for (int i = 5; i >= 0; i--) begin
            e.b    = bytes[8*i +: 8];
            e.p    = par[i];
            e.chkp = cp;
            expq.push_back(e);
        end
    endtask

    // Count done cycles.
    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
    end

    // UART receiver monitor: samples mid-bit on negedges and scores each byte at its stop bit.
    int         rx_cnt = 0;
    int         rx_k   = 0;
    bit         rx_act = 1'b0;
    logic [7:0] rx_b   = '0;
    logic       rx_p   = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (txd === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (((rx_cnt - 1) % CLK_DIV) == 0) begin
                rx_k = (rx_cnt - 1) / CLK_DIV;
                if (rx_k == 0) begin
                    chk("start_bit", {31'd0, txd}, 32'd0);
                end else if (rx_k <= 8) begin
                    rx_b[rx_k-1] = txd;
                end else if (rx_k < STOP_K) begin
                    rx_p = txd;
                end else begin
                    exp_t e;
                    chk("stop_bit", {31'd0, txd}, 32'd1);
                    if (expq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h expected none", rx_b);
                    end else begin
                        e = expq.pop_front();
                        chk("rx_byte", {24'd0, rx_b}, {24'd0, e.b});
                        if (e.chkp) chk("parity_bit", {31'd0, rx_p}, {31'd0, e.p});
                    end
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic pulse_and_measure(output int bcnt);
        int guard;
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        bcnt  = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 1000) begin
            bcnt++;
            guard++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, d0, gap, guard;

        // Reset with no clock running.
        #2;
        rst = 1'b1;
        #1;
        chk("rst_txd",  {31'd0, txd},  32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Channel 0, 05:42.
        mm_bus = {6'd20, 6'd5};
        ss_bus = {6'd11, 6'd42};
        ch_sel = 1'b0;
        d0 = n_done;
        push6({8'h30, 8'h35, 8'h3A, 8'h34, 8'h32, 8'h0D}, 6'b0, 1'b0);
        pulse_and_measure(bc);
        chk("busy_len_0542", bc, FRAME_CLKS);
        repeat (10) @(negedge clk);
        chk("done_once_0542", n_done - d0, 1);
        chk("q_empty_0542", expq.size(), 0);

        // Channel 1 saturates 63 -> 59, channel 0 ignored.
        mm_bus = {6'd63, 6'd12};
        ss_bus = {6'd0, 6'd34};
        ch_sel = 1'b1;
        d0 = n_done;
        push6({8'h35, 8'h39, 8'h3A, 8'h30, 8'h30, 8'h0D}, 6'b0, 1'b0);
        pulse_and_measure(bc);
        chk("busy_len_ch1", bc, FRAME_CLKS);
        repeat (10) @(negedge clk);
        chk("done_once_ch1", n_done - d0, 1);
        chk("q_empty_ch1", expq.size(), 0);

        // Mid-frame send is dropped; mid-frame input change is not seen.
        mm_bus = {6'd0, 6'd17};
        ss_bus = {6'd0, 6'd8};
        ch_sel = 1'b0;
        d0 = n_done;
        push6({8'h31, 8'h37, 8'h3A, 8'h30, 8'h38, 8'h0D}, 6'b0, 1'b0);
        fork
            pulse_and_measure(bc);
            begin
                repeat (50) @(negedge clk);
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
                repeat (9) @(negedge clk);
                mm_bus[5:0] = 6'd44;
                ch_sel = 1'b1;
            end
        join
        chk("busy_len_drop", bc, FRAME_CLKS);
        repeat (20) @(negedge clk);
        chk("no_requeue_busy", {31'd0, busy}, 32'd0);
        chk("done_once_drop", n_done - d0, 1);
        chk("q_empty_drop", expq.size(), 0);

        // Reset at clock 100 of a frame.
        mm_bus = {6'd0, 6'd22};
        ss_bus = {6'd0, 6'd33};
        ch_sel = 1'b0;
        d0 = n_done;
        push6({8'h32, 8'h32, 8'h3A, 8'h33, 8'h33, 8'h0D}, 6'b0, 1'b0);
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (99) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_txd",  {31'd0, txd},  32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        expq.delete();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);
        mm_bus = {6'd0, 6'd9};
        ss_bus = {6'd0, 6'd59};
        push6({8'h30, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h0D}, 6'b0, 1'b0);
        pulse_and_measure(bc);
        chk("busy_len_after_rst", bc, FRAME_CLKS);
        repeat (10) @(negedge clk);
        chk("done_after_rst", n_done - d0, 1);
        chk("q_empty_after_rst", expq.size(), 0);

        // send held high: second frame accepted in the done cycle.
        mm_bus = {6'd0, 6'd30};
        ss_bus = {6'd0, 6'd1};
        d0 = n_done;
        push6({8'h33, 8'h30, 8'h3A, 8'h30, 8'h31, 8'h0D}, 6'b0, 1'b0);
        push6({8'h33, 8'h30, 8'h3A, 8'h30, 8'h31, 8'h0D}, 6'b0, 1'b0);
        @(negedge clk);
        send = 1'b1;
        guard = 0;
        while (busy !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        bc = 0;
        while (busy === 1'b1 && bc < 1000) begin
            bc++;
            @(negedge clk);
        end
        chk("b2b_len1", bc, FRAME_CLKS);
        gap = 0;
        while (busy !== 1'b1 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        send = 1'b0;
        chk("b2b_gap", gap, 1);
        bc = 0;
        while (busy === 1'b1 && bc < 1000) begin
            bc++;
            @(negedge clk);
        end
        chk("b2b_len2", bc, FRAME_CLKS);
        repeat (10) @(negedge clk);
        chk("b2b_done", n_done - d0, 2);
        chk("q_empty_b2b", expq.size(), 0);

        // 01:00 with parity bits 0,1,0,0,0,1 when parity is built in.
        mm_bus = {6'd0, 6'd1};
        ss_bus = {6'd0, 6'd0};
        push6({8'h30, 8'h31, 8'h3A, 8'h30, 8'h30, 8'h0D}, 6'b010001, (PAR == 1));
        pulse_and_measure(bc);
        chk("busy_len_0100", bc, FRAME_CLKS);
        repeat (10) @(negedge clk);
        chk("q_empty_0100", expq.size(), 0);
        chk("idle_txd", {31'd0, txd}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_time_tx.md
UART_TIME_TX -- requirements
Module: uart_time_tx

Interface
REQ-001 Parameter CLK_DIV, default 1085, clocks per UART bit period; legal range 4..4095.
REQ-002 Parameter SELW, default 1, channel-select width; channel count NCH = 2**SELW.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ch_sel  input  SELW  channel index sampled at frame acceptance.
REQ-006 mm_bus  input  6*NCH  packed minutes per channel; channel k occupies bits [6k+5:6k].
REQ-007 ss_bus  input  6*NCH  packed seconds per channel, same packing as mm_bus.
REQ-008 send  input  1  frame request, level-sampled each cycle.
REQ-009 busy  output  1  high while a frame is in flight.
REQ-010 done  output  1  one-cycle pulse after the final stop bit.
REQ-011 txd  output  1  registered UART line, idle high.

Function
REQ-012 Block shall accept send only when busy=0, and shall latch the selected channel's mm and ss into internal registers in the same cycle.
REQ-013 After acceptance, the block shall ignore changes on mm_bus, ss_bus and ch_sel until the frame completes.
REQ-014 Latched values above 59 shall saturate to 59 before formatting.
REQ-015 Frame shall be 6 characters in order: ASCII minutes tens, minutes ones, 0x3A, seconds tens, seconds ones, 0x0D.
REQ-016 Tens digit shall be "0"+value/10 and ones digit shall be "0"+value%10, with a leading "0" always sent.
REQ-017 Each character shall be sent as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
REQ-018 Every bit shall last exactly CLK_DIV clocks, timed by a baud counter that restarts at 0 on acceptance.
REQ-019 txd shall go low on the first clock edge after the acceptance edge.
REQ-020 Characters shall be back-to-back, with no idle bits between a stop bit and the next start bit.
REQ-021 FSM states shall be IDLE, START, DATA, PARITY (macro only), STOP; a 3-bit bit counter shall run 0..7 in DATA and a 3-bit char index shall run 0..5.
REQ-022 FSM transitions: IDLE->START on accept; START->DATA; DATA->DATA until bit 7; DATA->STOP, or DATA->PARITY->STOP when the macro is defined; STOP->START if char index <5, else STOP->IDLE.
REQ-023 On STOP->IDLE, busy shall fall and done shall be high for exactly one cycle.
REQ-024 send high in the done cycle shall be accepted, starting a new frame with no extra idle bit.
REQ-025 send held high continuously shall produce frames back-to-back.
REQ-026 send during busy=1 shall be dropped and shall not be queued.
REQ-027 busy shall be high from the cycle after acceptance through the last stop-bit clock.

Reset
REQ-028 While rst=1, outputs shall be txd=1, busy=0 and done=0, and the FSM shall be in IDLE with all counters and latches at 0.
REQ-029 rst asserted mid-frame shall force txd=1 immediately, independent of clk, and shall discard the frame without a done pulse.
REQ-030 After rst deasserts, the first send shall start a complete frame from character 0.

Configuration
REQ-031 When macro UART_TIME_TX_PARITY_EN is defined, an even-parity bit (XOR of the 8 data bits) shall follow bit 7, giving 11 bits per character and a frame of 66*CLK_DIV clocks.
REQ-032 When UART_TIME_TX_PARITY_EN is undefined, the PARITY state and logic shall be absent, giving 10 bits per character and a frame of 60*CLK_DIV clocks.

Verification (CLK_DIV=4, SELW=1)
REQ-033 Assert rst with no clock running -> txd=1, busy=0, done=0 immediately.
REQ-034 ch_sel=0, mm=5, ss=42, send pulse -> bytes 0x30 0x35 0x3A 0x34 0x32 0x0D; 240 clocks of busy; one done pulse.
REQ-035 ch_sel=1, channel 1 mm=63, ss=0 -> "59:00\r"; channel 0 data must not appear.
REQ-036 send pulse at clock 50 of a frame, with mm changed at clock 60 -> exactly one frame carrying the originally latched values.
REQ-037 rst pulse at clock 100 of a frame -> txd=1 at once, no done; a new send then yields a full frame.
REQ-038 With UART_TIME_TX_PARITY_EN defined, mm=1, ss=0 -> parity bits 0,1,0,0,0,1 for the six characters; 264 clocks per frame.
